// File: rtl/scaler_out_framer.sv
// scaler_out_framer
// Tags each pixel of the push-only scaler stream with its frame/line position
// (derived from the programmed output resolution) and buffers it in a
// show-ahead FIFO that drives a valid/ready stream with sof/eol sideband.
// Overflow (pixel arriving while full) and short frames (vsync before the
// frame completed) are reported through sticky flags.
module scaler_out_framer #(
  parameter int DATA_WIDTH         = 24,
  parameter int OUTPUT_X_RES_WIDTH = 11,
  parameter int OUTPUT_Y_RES_WIDTH = 11,
  parameter int FIFO_AW            = 9
) (
  input  logic                          clk_hdmi,
  input  logic                          rst_n,
  input  logic                          vsync_in,
  input  logic                          din_valid,
  input  logic [31:0]                   din,
  input  logic [OUTPUT_X_RES_WIDTH-1:0] outputXRes,
  input  logic [OUTPUT_Y_RES_WIDTH-1:0] outputYRes,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          short_frame,
  output logic [FIFO_AW:0]              fifo_level
);

  localparam int XW    = OUTPUT_X_RES_WIDTH;
  localparam int YW    = OUTPUT_Y_RES_WIDTH;
  localparam int EW    = DATA_WIDTH + 2;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [XW-1:0]      X_ONE      = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0]      Y_ONE      = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0]      X_ZERO     = {XW{1'b0}};
  localparam logic [YW-1:0]      Y_ZERO     = {YW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ZERO   = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LEVEL_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW+1)'(DEPTH);

  // vsync edge detection
  logic vsync_q;
  logic vsync_q2;
  logic rise;

  // programmed geometry and position counters
  logic [XW-1:0] x_res;
  logic [YW-1:0] y_res;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // effective position of the pixel presented this cycle
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] cur_xres;
  logic [YW-1:0] cur_yres;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          x_last;
  logic          y_last;
  logic          pix_sof;

  // input register stage
  logic                  din_valid_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  sof_q;
  logic                  eol_q;

  // FIFO storage and control
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level_nxt;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [EW-1:0]      rd_word;

  // upper byte of the scaler word carries no pixel information
  logic unused_din;
  assign unused_din = ^din[31:DATA_WIDTH];

  assign rise = vsync_q & ~vsync_q2;

  // Position of the incoming pixel; a pixel in the rise cycle starts the new frame
  always_comb begin
    cur_x    = x_cnt;
    cur_y    = y_cnt;
    cur_xres = x_res;
    cur_yres = y_res;
    if (rise) begin
      cur_x    = X_ZERO;
      cur_y    = Y_ZERO;
      cur_xres = outputXRes;
      cur_yres = outputYRes;
    end else begin
      cur_x    = x_cnt;
      cur_y    = y_cnt;
      cur_xres = x_res;
      cur_yres = y_res;
    end
    // resolution 0 wraps to all-ones here: tagging is meaningless but nothing stalls
    x_last  = (cur_x == (cur_xres - X_ONE));
    y_last  = (cur_y == (cur_yres - Y_ONE));
    pix_sof = (cur_x == X_ZERO) && (cur_y == Y_ZERO);
  end

  // Next counter values: advance on every scaler pixel, wrapping line and frame
  always_comb begin
    x_nxt = cur_x;
    y_nxt = cur_y;
    if (din_valid) begin
      if (x_last) begin
        x_nxt = X_ZERO;
        if (y_last) begin
          y_nxt = Y_ZERO;
        end else begin
          y_nxt = cur_y + Y_ONE;
        end
      end else begin
        x_nxt = cur_x + X_ONE;
        y_nxt = cur_y;
      end
    end else begin
      x_nxt = cur_x;
      y_nxt = cur_y;
    end
  end

  // Frame tracking: vsync edge, resolution latch, counters, short-frame flag
  always_ff @(posedge clk_hdmi or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      vsync_q2    <= 1'b0;
      x_res       <= X_ZERO;
      y_res       <= Y_ZERO;
      x_cnt       <= X_ZERO;
      y_cnt       <= Y_ZERO;
      short_frame <= 1'b0;
    end else begin
      vsync_q  <= vsync_in;
      vsync_q2 <= vsync_q;
      if (rise) begin
        x_res <= outputXRes;
        y_res <= outputYRes;
        if ((x_cnt != X_ZERO) || (y_cnt != Y_ZERO)) begin
          short_frame <= 1'b1;
        end
      end
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  // Input stage: register pixel with its tags; frame_done lines up with the FIFO write
  always_ff @(posedge clk_hdmi or negedge rst_n) begin
    if (!rst_n) begin
      din_valid_q <= 1'b0;
      din_q       <= {DATA_WIDTH{1'b0}};
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      din_valid_q <= din_valid;
      din_q       <= din[DATA_WIDTH-1:0];
      sof_q       <= pix_sof;
      eol_q       <= x_last;
      frame_done  <= din_valid & x_last & y_last;
    end
  end

  // FIFO handshake: full is judged before the pop, so a push into a full FIFO is lost
  always_comb begin
    fifo_full = (fifo_level == LEVEL_FULL);
    push      = din_valid_q & ~fifo_full;
    pop       = m_valid & m_ready;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + LEVEL_ONE;
      2'b01:   level_nxt = fifo_level - LEVEL_ONE;
      default: level_nxt = fifo_level;
    endcase
  end

  // FIFO pointers, occupancy, output valid and overflow flag
  always_ff @(posedge clk_hdmi or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= PTR_ZERO;
      rd_ptr     <= PTR_ZERO;
      fifo_level <= LEVEL_ZERO;
      m_valid    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_level <= level_nxt;
      m_valid    <= (level_nxt != LEVEL_ZERO);
      if (din_valid_q && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage write: {sof, eol, pixel}
  always_ff @(posedge clk_hdmi) begin
    if (push) begin
      mem[wr_ptr] <= {sof_q, eol_q, din_q};
    end
  end

  // Show-ahead read; outputs forced to 0 while empty so stale words never leak
  always_comb begin
    rd_word = mem[rd_ptr];
    if (m_valid) begin
      m_data = rd_word[DATA_WIDTH-1:0];
      m_sof  = rd_word[EW-1];
      m_eol  = rd_word[EW-2];
    end else begin
      m_data = {DATA_WIDTH{1'b0}};
      m_sof  = 1'b0;
      m_eol  = 1'b0;
    end
  end

endmodule

// File: tb/tb_scaler_out_framer.sv
// Directed bench for scaler_out_framer: instance a uses the default 512-deep
// FIFO, instance b an 8-deep FIFO; both see the same input stream.
module tb_scaler_out_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync_in;
  logic        din_valid;
  logic [31:0] din;
  logic [10:0] xres;
  logic [10:0] yres;
  logic        m_ready_a;
  logic        m_ready_b;

  logic        m_valid_a, m_sof_a, m_eol_a, frame_done_a, overflow_a, short_frame_a;
  logic [23:0] m_data_a;
  logic [9:0]  fifo_level_a;
  logic        m_valid_b, m_sof_b, m_eol_b, frame_done_b, overflow_b, short_frame_b;
  logic [23:0] m_data_b;
  logic [3:0]  fifo_level_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scaler_out_framer dut_a (
    .clk_hdmi(clk), .rst_n(rst_n), .vsync_in(vsync_in), .din_valid(din_valid), .din(din),
    .outputXRes(xres), .outputYRes(yres), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_sof(m_sof_a), .m_eol(m_eol_a), .frame_done(frame_done_a),
    .overflow(overflow_a), .short_frame(short_frame_a), .fifo_level(fifo_level_a)
  );

  scaler_out_framer #(.FIFO_AW(3)) dut_b (
    .clk_hdmi(clk), .rst_n(rst_n), .vsync_in(vsync_in), .din_valid(din_valid), .din(din),
    .outputXRes(xres), .outputYRes(yres), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_sof(m_sof_b), .m_eol(m_eol_b), .frame_done(frame_done_b),
    .overflow(overflow_b), .short_frame(short_frame_b), .fifo_level(fifo_level_b)
  );

  function automatic logic [23:0] pval(input int i);
    return 24'h100000 + i[23:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int i);
    din_valid = 1'b1;
    din       = {8'hA5, pval(i)};
  endtask

  task automatic do_vsync(input logic [10:0] xr, input logic [10:0] yr);
    xres     = xr;
    yres     = yr;
    vsync_in = 1'b1;
    tick;
    tick;
    vsync_in = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vsync_in = 1'b0; din_valid = 1'b0; din = 32'd0;
    xres = 11'd0; yres = 11'd0; m_ready_a = 1'b0; m_ready_b = 1'b0;
    tick;
    tick;
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h expected 0", m_valid_a); end
    n_cmp++; if (m_data_a !== 24'd0) begin n_err++; $display("FAIL rst_data: got %0h expected 0", m_data_a); end
    n_cmp++; if (fifo_level_a !== 10'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", fifo_level_a); end
    n_cmp++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %0h expected 0", overflow_a); end
    n_cmp++; if (short_frame_a !== 1'b0) begin n_err++; $display("FAIL rst_short: got %0h expected 0", short_frame_a); end
    n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL rst_valid_b: got %0h expected 0", m_valid_b); end
    rst_n = 1'b1;
    tick;
  endtask

  // X=4,Y=2: 8 back-to-back pixels, always ready, latency 2
  task automatic test_stream;
    int fd;
    fd = 0;
    m_ready_a = 1'b1; m_ready_b = 1'b1;
    do_vsync(11'd4, 11'd2);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) pix(c); else din_valid = 1'b0;
      tick;
      if (frame_done_a) fd++;
      if (c == 7) begin
        n_cmp++; if (frame_done_a !== 1'b1) begin n_err++; $display("FAIL t1_frame_done: got %0h expected 1", frame_done_a); end
      end
      if (c == 0 || c == 9) begin
        n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL t1_idle c=%0d: got %0h expected 0", c, m_valid_a); end
      end else begin
        n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL t1_valid c=%0d: got %0h expected 1", c, m_valid_a); end
        n_cmp++; if (m_data_a !== pval(c-1)) begin n_err++; $display("FAIL t1_data c=%0d: got %0h expected %0h", c, m_data_a, pval(c-1)); end
        n_cmp++; if (m_sof_a !== (c == 1)) begin n_err++; $display("FAIL t1_sof c=%0d: got %0h expected %0h", c, m_sof_a, (c == 1)); end
        n_cmp++; if (m_eol_a !== (c == 4 || c == 8)) begin n_err++; $display("FAIL t1_eol c=%0d: got %0h expected %0h", c, m_eol_a, (c == 4 || c == 8)); end
      end
    end
    n_cmp++; if (fd !== 1) begin n_err++; $display("FAIL t1_frame_done_count: got %0d expected 1", fd); end
  endtask

  // 16-pixel burst while the writer stalls for 20 cycles
  task automatic test_backpressure;
    m_ready_a = 1'b0; m_ready_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) pix(16 + c); else din_valid = 1'b0;
      tick;
      if (c >= 1) begin
        n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL t2_hold_valid c=%0d: got %0h expected 1", c, m_valid_a); end
        n_cmp++; if (m_data_a !== pval(16)) begin n_err++; $display("FAIL t2_hold_data c=%0d: got %0h expected %0h", c, m_data_a, pval(16)); end
      end
    end
    n_cmp++; if (fifo_level_a !== 10'd16) begin n_err++; $display("FAIL t2_level: got %0d expected 16", fifo_level_a); end
    m_ready_a = 1'b1;
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL t2_drain_valid j=%0d: got %0h expected 1", j, m_valid_a); end
      n_cmp++; if (m_data_a !== pval(16 + j)) begin n_err++; $display("FAIL t2_drain_data j=%0d: got %0h expected %0h", j, m_data_a, pval(16 + j)); end
      n_cmp++; if (m_sof_a !== (j % 8 == 0)) begin n_err++; $display("FAIL t2_sof j=%0d: got %0h expected %0h", j, m_sof_a, (j % 8 == 0)); end
      n_cmp++; if (m_eol_a !== (j % 4 == 3)) begin n_err++; $display("FAIL t2_eol j=%0d: got %0h expected %0h", j, m_eol_a, (j % 4 == 3)); end
      tick;
    end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL t2_empty: got %0h expected 0", m_valid_a); end
    n_cmp++; if (fifo_level_a !== 10'd0) begin n_err++; $display("FAIL t2_level_end: got %0d expected 0", fifo_level_a); end
  endtask

  // 8-deep FIFO, 10 pixels without ready: last two dropped, geometry kept
  task automatic test_overflow;
    m_ready_a = 1'b1; m_ready_b = 1'b0;
    do_vsync(11'd5, 11'd2);
    n_cmp++; if (short_frame_a !== 1'b0) begin n_err++; $display("FAIL t3_short: got %0h expected 0", short_frame_a); end
    for (int c = 0; c < 10; c++) begin
      pix(40 + c);
      tick;
    end
    din_valid = 1'b0;
    tick; tick; tick;
    n_cmp++; if (fifo_level_b !== 4'd8) begin n_err++; $display("FAIL t3_level: got %0d expected 8", fifo_level_b); end
    n_cmp++; if (overflow_b !== 1'b1) begin n_err++; $display("FAIL t3_overflow: got %0h expected 1", overflow_b); end
    n_cmp++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL t3_overflow_deep: got %0h expected 0", overflow_a); end
    m_ready_b = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (m_data_b !== pval(40 + j)) begin n_err++; $display("FAIL t3_data j=%0d: got %0h expected %0h", j, m_data_b, pval(40 + j)); end
      n_cmp++; if (m_sof_b !== (j == 0)) begin n_err++; $display("FAIL t3_sof j=%0d: got %0h expected %0h", j, m_sof_b, (j == 0)); end
      n_cmp++; if (m_eol_b !== (j == 4)) begin n_err++; $display("FAIL t3_eol j=%0d: got %0h expected %0h", j, m_eol_b, (j == 4)); end
      tick;
    end
    n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL t3_dropped_absent: got %0h expected 0", m_valid_b); end
    for (int c = 0; c < 12; c++) begin
      if (c < 10) pix(60 + c); else din_valid = 1'b0;
      tick;
      if (c == 0 || c == 11) begin
        n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL t3_next_idle c=%0d: got %0h expected 0", c, m_valid_b); end
      end else begin
        n_cmp++; if (m_data_b !== pval(59 + c)) begin n_err++; $display("FAIL t3_next_data c=%0d: got %0h expected %0h", c, m_data_b, pval(59 + c)); end
        n_cmp++; if (m_sof_b !== (c == 1)) begin n_err++; $display("FAIL t3_next_sof c=%0d: got %0h expected %0h", c, m_sof_b, (c == 1)); end
        n_cmp++; if (m_eol_b !== (c == 5 || c == 10)) begin n_err++; $display("FAIL t3_next_eol c=%0d: got %0h expected %0h", c, m_eol_b, (c == 5 || c == 10)); end
      end
    end
  endtask

  // vsync after 5 of 8 pixels; the pixel in the rise cycle opens the new frame
  task automatic test_short_frame;
    m_ready_a = 1'b0; m_ready_b = 1'b1;
    do_vsync(11'd4, 11'd2);
    n_cmp++; if (short_frame_a !== 1'b0) begin n_err++; $display("FAIL t4_short_before: got %0h expected 0", short_frame_a); end
    for (int c = 0; c < 5; c++) begin
      pix(80 + c);
      tick;
    end
    din_valid = 1'b0;
    tick;
    vsync_in = 1'b1;
    tick;
    for (int c = 5; c < 9; c++) begin
      pix(80 + c);
      tick;
    end
    din_valid = 1'b0;
    vsync_in  = 1'b0;
    tick; tick; tick;
    n_cmp++; if (short_frame_a !== 1'b1) begin n_err++; $display("FAIL t4_short: got %0h expected 1", short_frame_a); end
    n_cmp++; if (fifo_level_a !== 10'd9) begin n_err++; $display("FAIL t4_level: got %0d expected 9", fifo_level_a); end
    m_ready_a = 1'b1;
    for (int j = 0; j < 9; j++) begin
      n_cmp++; if (m_data_a !== pval(80 + j)) begin n_err++; $display("FAIL t4_data j=%0d: got %0h expected %0h", j, m_data_a, pval(80 + j)); end
      n_cmp++; if (m_sof_a !== (j == 0 || j == 5)) begin n_err++; $display("FAIL t4_sof j=%0d: got %0h expected %0h", j, m_sof_a, (j == 0 || j == 5)); end
      n_cmp++; if (m_eol_a !== (j == 3 || j == 8)) begin n_err++; $display("FAIL t4_eol j=%0d: got %0h expected %0h", j, m_eol_a, (j == 3 || j == 8)); end
      tick;
    end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL t4_empty: got %0h expected 0", m_valid_a); end
  endtask

  // Full 8-deep FIFO with push and pop in the same cycle
  task automatic test_full_push_pop;
    rst_n = 1'b0;
    din_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    m_ready_a = 1'b1; m_ready_b = 1'b0;
    do_vsync(11'd4, 11'd4);
    for (int c = 0; c < 8; c++) begin
      pix(100 + c);
      tick;
    end
    din_valid = 1'b0;
    tick; tick; tick;
    n_cmp++; if (fifo_level_b !== 4'd8) begin n_err++; $display("FAIL t5_level_full: got %0d expected 8", fifo_level_b); end
    n_cmp++; if (overflow_b !== 1'b0) begin n_err++; $display("FAIL t5_overflow_before: got %0h expected 0", overflow_b); end
    pix(108);
    tick;
    din_valid = 1'b0;
    m_ready_b = 1'b1;
    tick;
    m_ready_b = 1'b0;
    n_cmp++; if (fifo_level_b !== 4'd7) begin n_err++; $display("FAIL t5_level_after: got %0d expected 7", fifo_level_b); end
    n_cmp++; if (overflow_b !== 1'b1) begin n_err++; $display("FAIL t5_overflow: got %0h expected 1", overflow_b); end
    m_ready_b = 1'b1;
    for (int j = 1; j < 8; j++) begin
      n_cmp++; if (m_data_b !== pval(100 + j)) begin n_err++; $display("FAIL t5_data j=%0d: got %0h expected %0h", j, m_data_b, pval(100 + j)); end
      n_cmp++; if (m_eol_b !== (j == 3 || j == 7)) begin n_err++; $display("FAIL t5_eol j=%0d: got %0h expected %0h", j, m_eol_b, (j == 3 || j == 7)); end
      tick;
    end
    n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("FAIL t5_dropped_absent: got %0h expected 0", m_valid_b); end
  endtask

  // Asynchronous reset in the middle of a burst
  task automatic test_reset_mid;
    m_ready_a = 1'b0; m_ready_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      pix(120 + c);
      tick;
    end
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("FAIL t6_valid: got %0h expected 0", m_valid_a); end
    n_cmp++; if (m_data_a !== 24'd0) begin n_err++; $display("FAIL t6_data: got %0h expected 0", m_data_a); end
    n_cmp++; if (m_sof_a !== 1'b0) begin n_err++; $display("FAIL t6_sof: got %0h expected 0", m_sof_a); end
    n_cmp++; if (fifo_level_a !== 10'd0) begin n_err++; $display("FAIL t6_level: got %0d expected 0", fifo_level_a); end
    n_cmp++; if (overflow_b !== 1'b0) begin n_err++; $display("FAIL t6_overflow: got %0h expected 0", overflow_b); end
    n_cmp++; if (frame_done_a !== 1'b0) begin n_err++; $display("FAIL t6_frame_done: got %0h expected 0", frame_done_a); end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    pix(130);
    tick;
    din_valid = 1'b0;
    tick;
    n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("FAIL t6_post_valid: got %0h expected 1", m_valid_a); end
    n_cmp++; if (m_sof_a !== 1'b1) begin n_err++; $display("FAIL t6_post_sof: got %0h expected 1", m_sof_a); end
    n_cmp++; if (m_data_a !== pval(130)) begin n_err++; $display("FAIL t6_post_data: got %0h expected %0h", m_data_a, pval(130)); end
    n_cmp++; if (fifo_level_a !== 10'd1) begin n_err++; $display("FAIL t6_post_level: got %0d expected 1", fifo_level_a); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_overflow;
    test_short_frame;
    test_full_push_pop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
